motor_arbiter: RTL and testbench
================================

MOTOR_ARBITER -- requirements
Module: motor_arbiter

Interface
REQ-001 Parameter T_FWD, default 10, forward-phase length in clk cycles (legal 1..255).
REQ-002 Parameter T_GAP, default 2, dead-time length between forward and reverse phases in cycles (legal 1..255).
REQ-003 Parameter T_REV, default 5, reverse-phase length in clk cycles (legal 1..255).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 stop  input  1  emergency stop, level-sensitive, synchronous.
REQ-007 enable  input  1  master enable (door closed); low pauses operation.
REQ-008 req  input  2  level requests, bit0 = motor 1, bit1 = motor 2; held until done.
REQ-009 grant  output  2  one-hot owner of the shared motor driver, 00 when none.
REQ-010 dir  output  2  shared driver command: 00 off, 01 forward, 10 reverse; 11 never driven.
REQ-011 done  output  2  one-cycle completion pulse, bit per motor.
REQ-012 busy  output  1  high in any state except IDLE and HALT.
REQ-013 halted  output  1  high in HALT.

Function
REQ-014 FSM states: IDLE, FWD, GAP, REV, DONE, HALT; all outputs registered or decoded from state only.
REQ-015 IDLE: stop=1 -> HALT; else enable=1 and req!=00 -> FWD with grant latched; else stay.
REQ-016 Arbitration round-robin: both requesting -> grant motor not last served; single request -> that motor.
REQ-017 Last-served pointer updates only in DONE; reset value = motor 2, so motor 1 wins first tie.
REQ-018 FWD lasts exactly T_FWD active cycles with dir=01, then GAP.
REQ-019 GAP lasts exactly T_GAP active cycles with dir=00, then REV.
REQ-020 REV lasts exactly T_REV active cycles with dir=10, then DONE.
REQ-021 DONE lasts one cycle: done[owner]=1, dir=00, grant still asserted; next state IDLE, grant cleared.
REQ-022 enable=0 in FWD/GAP/REV: dir=00, phase counter frozen, state held; enable=1 resumes remaining count (paused cycles are not active cycles).
REQ-023 stop=1 in any state except HALT -> HALT next cycle; no done pulse; grant=00, dir=00, counter cleared.
REQ-024 HALT: held while stop=1; stop=0 -> IDLE; aborted operation is not resumed, a new grant restarts FWD with full count.
REQ-025 stop has priority over enable and over phase completion in the same cycle.
REQ-026 Requester dropping req mid-operation is ignored; operation completes.
REQ-027 Phase counter width 8 bits; loaded with T-1 on phase entry, decremented per active cycle, phase ends at 0; no wrap-around.

Reset
REQ-028 reset=0 asynchronously forces state IDLE, counter 0, pointer = motor 2, grant=00, dir=00, done=00, busy=0, halted=0.
REQ-029 Reset asserted mid-operation aborts with no done pulse; first edge after release evaluates IDLE.

Structure
REQ-030 Shared package motor_pkg holds state enum, dir encodings (DIR_OFF, DIR_FWD, DIR_REV) and default T_FWD/T_GAP/T_REV constants.
REQ-031 One sub-module phase_timer: 8-bit loadable down-counter with load, run (enable) and zero flag, replacing delay-based timers; fully synthesizable, no # delays.

Verification (T_FWD=4, T_GAP=1, T_REV=2, enable=1)
REQ-032 req=01 at cycle 0 -> grant=01 cycles 1-8; dir=01 cycles 1-4, 00 cycle 5, 10 cycles 6-7; done=01 at cycle 8; IDLE cycle 9.
REQ-033 req=11 held -> motor 1 served cycles 1-8, done=01 at 8; grant=10 from cycle 10, done=10 at 17; then motor 1 again.
REQ-034 stop=1 at cycle 3 (in FWD) -> cycle 4 halted=1, grant=00, dir=00, no done; stop=0 -> IDLE, regrant gives full 4 FWD cycles.
REQ-035 enable=0 for 3 cycles during first REV cycle -> dir=00 while paused, REV resumes for exactly 1 more cycle, done delayed 3 cycles.
REQ-036 reset=0 asynchronously mid-GAP -> all outputs 0 immediately without clock; after release, req=11 grants motor 1 first.
REQ-037 T_FWD=T_GAP=T_REV=1 -> each phase exactly one cycle, done at cycle 4.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the shared-driver motor arbiter.
// Holds the FSM state enum, driver direction codes and default phase lengths.
package motor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFwd,
    StGap,
    StRev,
    StDone,
    StHalt
  } state_e;

  localparam logic [1:0] DIR_OFF = 2'b00;
  localparam logic [1:0] DIR_FWD = 2'b01;
  localparam logic [1:0] DIR_REV = 2'b10;

  localparam int unsigned T_FWD_DEFAULT = 10;
  localparam int unsigned T_GAP_DEFAULT = 2;
  localparam int unsigned T_REV_DEFAULT = 5;

  localparam int CntW = 8;

  // Round-robin pick: on a tie the motor not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_m2);
    case (req)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return last_m2 ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 8-bit down-counter timing the FWD/GAP/REV phases.
// Clear beats load, load beats run; the count saturates at zero.
module phase_timer
  import motor_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            run_i,
  input  logic            clear_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/motor_arbiter.sv
// Round-robin arbiter sharing one motor driver between two motors.
// Each grant runs forward, dead-time gap, reverse, then a one-cycle done pulse.
module motor_arbiter
  import motor_pkg::*;
#(
  parameter int unsigned T_FWD = T_FWD_DEFAULT,
  parameter int unsigned T_GAP = T_GAP_DEFAULT,
  parameter int unsigned T_REV = T_REV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stop,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic [1:0] dir,
  output logic [1:0] done,
  output logic       busy,
  output logic       halted
);

  localparam logic [CntW-1:0] FwdLoad = CntW'(T_FWD - 1);
  localparam logic [CntW-1:0] GapLoad = CntW'(T_GAP - 1);
  localparam logic [CntW-1:0] RevLoad = CntW'(T_REV - 1);

  state_e          state_d, state_q;
  logic [1:0]      grant_d, grant_q;
  logic            last_m2_d, last_m2_q;
  logic            tmr_load, tmr_run, tmr_clear, tmr_zero;
  logic [CntW-1:0] tmr_val;

  phase_timer u_phase_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .run_i      (tmr_run),
    .clear_i    (tmr_clear),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_m2_d = last_m2_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_run   = 1'b0;
    tmr_clear = 1'b0;

    case (state_q)
      StIdle: begin
        if (stop) begin
          state_d   = StHalt;
          tmr_clear = 1'b1;
        end else if (enable && (req != 2'b00)) begin
          state_d  = StFwd;
          grant_d  = rr_pick(req, last_m2_q);
          tmr_load = 1'b1;
          tmr_val  = FwdLoad;
        end
      end

      StFwd, StGap, StRev: begin
        // Stop wins over both enable and a phase ending this cycle.
        if (stop) begin
          state_d   = StHalt;
          grant_d   = 2'b00;
          tmr_clear = 1'b1;
        end else if (enable) begin
          if (!tmr_zero) begin
            tmr_run = 1'b1;
          end else begin
            case (state_q)
              StFwd: begin
                state_d  = StGap;
                tmr_load = 1'b1;
                tmr_val  = GapLoad;
              end
              StGap: begin
                state_d  = StRev;
                tmr_load = 1'b1;
                tmr_val  = RevLoad;
              end
              default: begin
                state_d = StDone;
              end
            endcase
          end
        end
      end

      StDone: begin
        // The operation completed, so it counts as served even if stop hits now.
        last_m2_d = grant_q[1];
        grant_d   = 2'b00;
        if (stop) begin
          state_d   = StHalt;
          tmr_clear = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end

      StHalt: begin
        tmr_clear = 1'b1;
        grant_d   = 2'b00;
        if (!stop) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        grant_d   = 2'b00;
        tmr_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      last_m2_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_m2_q <= last_m2_d;
    end
  end

  // Pausing with enable low drops the drive immediately while state holds.
  always_comb begin
    dir = DIR_OFF;
    if (enable) begin
      if (state_q == StFwd) begin
        dir = DIR_FWD;
      end else if (state_q == StRev) begin
        dir = DIR_REV;
      end
    end
  end

  assign grant  = grant_q;
  assign done   = (state_q == StDone) ? grant_q : 2'b00;
  assign busy   = (state_q != StIdle) && (state_q != StHalt);
  assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_motor_arbiter.sv
// Bench for motor_arbiter: two DUTs (4/1/2 and 1/1/1 phase lengths) share stimulus
// and are checked every cycle against a phase/remaining-count reference model.
module tb_motor_arbiter;

  logic       clk;
  logic       reset;
  logic       stop;
  logic       enable;
  logic [1:0] req;
  logic [1:0] grant_a, dir_a, done_a, grant_b, dir_b, done_b;
  logic       busy_a, halted_a, busy_b, halted_b;

  int tests = 0;
  int fails = 0;

  motor_arbiter #(.T_FWD(4), .T_GAP(1), .T_REV(2)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .stop   (stop),
    .enable (enable),
    .req    (req),
    .grant  (grant_a),
    .dir    (dir_a),
    .done   (done_a),
    .busy   (busy_a),
    .halted (halted_a)
  );

  motor_arbiter #(.T_FWD(1), .T_GAP(1), .T_REV(1)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .stop   (stop),
    .enable (enable),
    .req    (req),
    .grant  (grant_b),
    .dir    (dir_b),
    .done   (done_b),
    .busy   (busy_b),
    .halted (halted_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases: 0 idle, 1 fwd, 2 gap, 3 rev, 4 done, 5 halt.
  localparam int PIdle = 0;
  localparam int PFwd  = 1;
  localparam int PGap  = 2;
  localparam int PRev  = 3;
  localparam int PDone = 4;
  localparam int PHalt = 5;

  typedef struct {
    int ph;
    int rem;    // active cycles still to spend in the current phase
    int owner;  // 0 none, 1 motor 1, 2 motor 2
    int last;   // last motor served
  } mdl_t;

  mdl_t m_a, m_b;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.ph = PIdle; r.rem = 0; r.owner = 0; r.last = 2;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int lf, int lg, int lr,
                                    logic s, logic en, logic [1:0] r);
    mdl_t n = m;
    if (m.ph == PHalt) begin
      if (!s) n.ph = PIdle;
      return n;
    end
    if (m.ph == PDone) n.last = m.owner;
    if (s) begin
      n.ph = PHalt; n.owner = 0; n.rem = 0;
      return n;
    end
    case (m.ph)
      PIdle: if (en && r != 2'b00) begin
        if (r == 2'b11) n.owner = (m.last == 1) ? 2 : 1;
        else            n.owner = (r == 2'b01) ? 1 : 2;
        n.ph = PFwd; n.rem = lf;
      end
      PFwd, PGap, PRev: if (en) begin
        n.rem = m.rem - 1;
        if (n.rem == 0) begin
          n.ph  = m.ph + 1;
          n.rem = (m.ph == PFwd) ? lg : (m.ph == PGap) ? lr : 0;
        end
      end
      PDone: begin
        n.ph = PIdle; n.owner = 0;
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [1:0] e_grant(mdl_t m);
    return (m.owner == 1) ? 2'b01 : (m.owner == 2) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [1:0] e_dir(mdl_t m, logic en);
    if (!en) return 2'b00;
    if (m.ph == PFwd) return 2'b01;
    if (m.ph == PRev) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [1:0] e_done(mdl_t m);
    return (m.ph == PDone) ? e_grant(m) : 2'b00;
  endfunction

  task automatic chk(input string nm, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t: got %b expected %b", nm, $time, got, exp);
    end
  endtask

  // History of DUT outputs for the hand-computed cycle checks.
  logic [1:0] hg [0:63];
  logic [1:0] hd [0:63];
  logic [1:0] hdn[0:63];
  logic       hb [0:63];
  logic       hh [0:63];
  logic [1:0] h1d [0:63];
  logic [1:0] h1dn[0:63];
  int hc = 0;

  task automatic check_all();
    chk("A grant",  grant_a,           e_grant(m_a));
    chk("A dir",    dir_a,             e_dir(m_a, enable));
    chk("A done",   done_a,            e_done(m_a));
    chk("A busy",   {1'b0, busy_a},    {1'b0, (m_a.ph >= PFwd && m_a.ph <= PDone)});
    chk("A halted", {1'b0, halted_a},  {1'b0, (m_a.ph == PHalt)});
    chk("B grant",  grant_b,           e_grant(m_b));
    chk("B dir",    dir_b,             e_dir(m_b, enable));
    chk("B done",   done_b,            e_done(m_b));
    chk("B busy",   {1'b0, busy_b},    {1'b0, (m_b.ph >= PFwd && m_b.ph <= PDone)});
    chk("B halted", {1'b0, halted_b},  {1'b0, (m_b.ph == PHalt)});
    if (hc < 64) begin
      hg[hc] = grant_a; hd[hc] = dir_a; hdn[hc] = done_a; hb[hc] = busy_a; hh[hc] = halted_a;
      h1d[hc] = dir_b; h1dn[hc] = done_b;
    end
    hc++;
  endtask

  // Check mid-cycle, advance the model on the edge, then leave room for new inputs.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    m_a = mdl_step(m_a, 4, 1, 2, stop, enable, req);
    m_b = mdl_step(m_b, 1, 1, 1, stop, enable, req);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_a = mdl_reset();
    m_b = mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic drain(input int n);
    req = 2'b00; stop = 1'b0; enable = 1'b1;
    repeat (n) cycle();
  endtask

  initial begin
    stop = 1'b0; enable = 1'b1; req = 2'b00; reset = 1'b0;
    m_a = mdl_reset();
    m_b = mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset grant",  grant_a, 2'b00);
    chk("reset dir",    dir_a,   2'b00);
    chk("reset done",   done_a,  2'b00);
    chk("reset busy",   {1'b0, busy_a}, 2'b00);
    chk("reset halted", {1'b0, halted_a}, 2'b00);
    reset = 1'b1;

    // Single request, nominal sequence.
    hc = 0; req = 2'b01;
    repeat (9) cycle();
    req = 2'b00;
    cycle();
    chk("seq grant c1", hg[1], 2'b01);
    chk("seq grant c8", hg[8], 2'b01);
    chk("seq dir c1",   hd[1], 2'b01);
    chk("seq dir c4",   hd[4], 2'b01);
    chk("seq dir c5",   hd[5], 2'b00);
    chk("seq dir c6",   hd[6], 2'b10);
    chk("seq dir c7",   hd[7], 2'b10);
    chk("seq done c7",  hdn[7], 2'b00);
    chk("seq done c8",  hdn[8], 2'b01);
    chk("seq busy c9",  {1'b0, hb[9]}, 2'b00);
    chk("t1 dir c1",    h1d[1], 2'b01);
    chk("t1 dir c2",    h1d[2], 2'b00);
    chk("t1 dir c3",    h1d[3], 2'b10);
    chk("t1 done c3",   h1dn[3], 2'b00);
    chk("t1 done c4",   h1dn[4], 2'b01);
    drain(6);

    // Both requesting from reset: round-robin alternation.
    do_reset();
    hc = 0; req = 2'b11;
    repeat (20) cycle();
    req = 2'b00;
    repeat (9) cycle();
    chk("rr grant c1",  hg[1],  2'b01);
    chk("rr done c8",   hdn[8], 2'b01);
    chk("rr grant c10", hg[10], 2'b10);
    chk("rr done c17",  hdn[17], 2'b10);
    chk("rr grant c19", hg[19], 2'b01);
    drain(4);

    // Stop during forward phase, then regrant with a full count.
    hc = 0; req = 2'b01;
    repeat (3) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    repeat (3) cycle();
    req = 2'b00;
    repeat (12) cycle();
    chk("stop halted c4", {1'b0, hh[4]}, 2'b01);
    chk("stop grant c4",  hg[4],  2'b00);
    chk("stop dir c4",    hd[4],  2'b00);
    chk("stop done c4",   hdn[4], 2'b00);
    chk("stop busy c5",   {1'b0, hb[5]}, 2'b00);
    chk("stop dir c6",    hd[6],  2'b01);
    chk("stop dir c9",    hd[9],  2'b01);
    chk("stop dir c10",   hd[10], 2'b00);
    drain(4);

    // Pause for three cycles after the first reverse cycle.
    hc = 0; req = 2'b01;
    repeat (7) cycle();
    enable = 1'b0;
    repeat (3) cycle();
    enable = 1'b1;
    cycle();
    req = 2'b00;
    repeat (3) cycle();
    chk("pause dir c6",   hd[6],  2'b10);
    chk("pause dir c7",   hd[7],  2'b00);
    chk("pause dir c9",   hd[9],  2'b00);
    chk("pause busy c8",  {1'b0, hb[8]}, 2'b01);
    chk("pause dir c10",  hd[10], 2'b10);
    chk("pause done c10", hdn[10], 2'b00);
    chk("pause done c11", hdn[11], 2'b01);
    drain(4);

    // Asynchronous reset in the gap phase, away from any clock edge.
    hc = 0; req = 2'b01;
    repeat (5) cycle();
    chk("arst pre dir c4", hd[4], 2'b01);
    #2;
    reset = 1'b0;
    #1;
    chk("arst grant",  grant_a, 2'b00);
    chk("arst dir",    dir_a,   2'b00);
    chk("arst done",   done_a,  2'b00);
    chk("arst busy",   {1'b0, busy_a}, 2'b00);
    chk("arst halted", {1'b0, halted_a}, 2'b00);
    m_a = mdl_reset();
    m_b = mdl_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    hc = 0; req = 2'b11;
    repeat (3) cycle();
    chk("arst regrant c1", hg[1], 2'b01);
    drain(20);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (stop) stop = ($urandom_range(0, 1) == 0);
      else      stop = ($urandom_range(0, 39) == 0);
      enable = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      cycle();
    end
    drain(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
